// File: rtl/div_meter_pkg.sv
// div_meter_pkg: shared constants and FSM encoding for the divider
// measurement block.
//   ST_IDLE / ST_MEASURE : 2-bit FSM state encodings
//   DEF_CNT_W, DEF_LOCK_CNT : default parameter values
//   MATCH_W : width of the lock match counter (LOCK_CNT up to 15)
package div_meter_pkg;

   localparam int DEF_CNT_W    = 8;
   localparam int DEF_LOCK_CNT = 3;
   localparam int MATCH_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1
   } state_t;

endpackage

// File: rtl/div_meter_if.sv
// div_meter_if: signal under measurement plus measurement results.
//   sig_in     : divided clock / periodic signal under measurement
//   period     : clk_in cycles between the last two rising edges
//   high_len   : clk_in cycles sampled high within that period
//   meas_valid : one-cycle pulse when period/high_len update
//   locked     : waveform stable for LOCK_CNT consecutive matches
//   ovf        : sticky counter saturation flag
// master = the meter (drives results), slave = whoever supplies sig_in
// and consumes the results.
interface div_meter_if #(
   parameter int CNT_W = 8
);
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_len;
   logic             meas_valid;
   logic             locked;
   logic             ovf;

   modport master (
      input  sig_in,
      output period, high_len, meas_valid, locked, ovf
   );

   modport slave (
      output sig_in,
      input  period, high_len, meas_valid, locked, ovf
   );
endinterface

// File: rtl/div_meter_edge_sync.sv
// edge_sync: samples sig_in into s_q and flags its rising edges.
//   clk_in : source clock
//   rst    : synchronous active-high reset
//   sig_in : raw signal under measurement
//   s_q    : registered sample of sig_in
//   rise   : s_q high this cycle and low the cycle before
// Build option DIV_METER_SYNC_EN inserts a 2-flop synchronizer ahead of
// s_q for asynchronous sources (adds 2 cycles of latency).
module edge_sync (
   input  logic clk_in,
   input  logic rst,
   input  logic sig_in,
   output logic s_q,
   output logic rise
);

   logic s_prev;
   logic s_in;

`ifdef DIV_METER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_in) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], sig_in};
   end

   assign s_in = sync_q[1];
`else
   assign s_in = sig_in;
`endif

   always_ff @(posedge clk_in) begin
      if (rst) begin
         s_q    <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         s_q    <= s_in;
         s_prev <= s_q;
      end
   end

   assign rise = s_q & ~s_prev;

endmodule

// File: rtl/div_meter.sv
// div_meter: measures period and high-phase length of a divided clock in
// clk_in cycles, flags lock after LOCK_CNT consecutive identical
// measurements, and raises a sticky ovf when the period counter saturates.
//   clk_in : source clock (only clock)
//   rst    : synchronous active-high reset
//   bus    : div_meter_if.master (sig_in in; period, high_len,
//            meas_valid, locked, ovf out)
// Build option DIV_METER_SYNC_EN (see edge_sync) adds an input
// synchronizer; measured values are unchanged for synchronous stimulus.
//
// state      | meaning
// ST_IDLE    | waiting for the first rising edge of sig_in
// ST_MEASURE | counting period / high cycles between rising edges
module div_meter
   import div_meter_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic       clk_in,
   input  logic       rst,
   div_meter_if.master bus
);

   localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

   logic s_q;
   logic rise;

   state_t             state,     state_nxt;
   logic [CNT_W-1:0]   cnt_run,   cnt_nxt;
   logic [CNT_W-1:0]   hi_run,    hi_nxt;
   logic [CNT_W-1:0]   period_q,  period_nxt;
   logic [CNT_W-1:0]   high_q,    high_nxt;
   logic               valid_q,   valid_nxt;
   logic               locked_q,  locked_nxt;
   logic               ovf_q,     ovf_nxt;
   logic [MATCH_W-1:0] match_cnt, match_nxt;
   logic               have_prev, have_prev_nxt;

   edge_sync u_edge_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .sig_in (bus.sig_in),
      .s_q    (s_q),
      .rise   (rise)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt_run   <= '0;
         hi_run    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         ovf_q     <= 1'b0;
         match_cnt <= '0;
         have_prev <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt_run   <= cnt_nxt;
         hi_run    <= hi_nxt;
         period_q  <= period_nxt;
         high_q    <= high_nxt;
         valid_q   <= valid_nxt;
         locked_q  <= locked_nxt;
         ovf_q     <= ovf_nxt;
         match_cnt <= match_nxt;
         have_prev <= have_prev_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt_run;
      hi_nxt        = hi_run;
      period_nxt    = period_q;
      high_nxt      = high_q;
      valid_nxt     = 1'b0;
      locked_nxt    = locked_q;
      ovf_nxt       = ovf_q;
      match_nxt     = match_cnt;
      have_prev_nxt = have_prev;

      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_nxt     = ST_MEASURE;
               cnt_nxt       = CNT_ONE;
               hi_nxt        = CNT_ONE;
               have_prev_nxt = 1'b0;
            end
         end

         ST_MEASURE: begin
            if (rise) begin
               period_nxt    = cnt_run;
               high_nxt      = hi_run;
               valid_nxt     = 1'b1;
               cnt_nxt       = CNT_ONE;
               hi_nxt        = CNT_ONE;
               have_prev_nxt = 1'b1;
               if (cnt_run == CNT_MAX) begin
                  // edge coincides with saturation: period is not trustworthy
                  ovf_nxt    = 1'b1;
                  locked_nxt = 1'b0;
                  match_nxt  = '0;
               end else if (have_prev && cnt_run == period_q && hi_run == high_q) begin
                  match_nxt  = (match_cnt == LOCK_TGT) ? match_cnt : match_cnt + MATCH_W'(1);
                  locked_nxt = (match_nxt == LOCK_TGT);
               end else begin
                  match_nxt  = '0;
                  locked_nxt = 1'b0;
               end
            end else if (cnt_run == CNT_MAX) begin
               // no edge within counter range: give up, wait for a fresh first edge
               state_nxt  = ST_IDLE;
               ovf_nxt    = 1'b1;
               locked_nxt = 1'b0;
               match_nxt  = '0;
               cnt_nxt    = '0;
               hi_nxt     = '0;
            end else begin
               cnt_nxt = cnt_run + CNT_ONE;
               if (s_q && hi_run != CNT_MAX) hi_nxt = hi_run + CNT_ONE;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.period     = period_q;
   assign bus.high_len   = high_q;
   assign bus.meas_valid = valid_q;
   assign bus.locked     = locked_q;
   assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_div_meter.sv
module tb_div_meter;

   typedef struct {
      logic [7:0] p;
      logic [7:0] h;
      logic       lk;
   } exp_t;

`ifdef DIV_METER_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic clk_in = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   div_meter_if #(.CNT_W(8)) bus ();

   div_meter #(.CNT_W(8), .LOCK_CNT(3)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int p, input int h, input bit lk);
      exp_t e;
      e.p  = 8'(p);
      e.h  = 8'(h);
      e.lk = lk;
      sb.push_back(e);
   endtask

   task automatic gen(input int hi, input int lo);
      bus.sig_in = 1'b1;
      repeat (hi) @(negedge clk_in);
      bus.sig_in = 1'b0;
      repeat (lo) @(negedge clk_in);
   endtask

   // scoreboard consumer: every meas_valid must match the oldest expectation
   always @(negedge clk_in) begin
      if (bus.meas_valid === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_meas_valid observed=1 expected=0 period=%0d", bus.period);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("period", 32'(bus.period), 32'(e.p));
            check("high_len", 32'(bus.high_len), 32'(e.h));
            check("locked", 32'(bus.locked), 32'(e.lk));
         end
      end
   end

   initial begin
      int c;
      rst = 1'b1;
      bus.sig_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_period", 32'(bus.period), 0);
      check("rst_high_len", 32'(bus.high_len), 0);
      check("rst_meas_valid", 32'(bus.meas_valid), 0);
      check("rst_locked", 32'(bus.locked), 0);
      check("rst_ovf", 32'(bus.ovf), 0);
      rst = 1'b0;
      @(negedge clk_in);

      // divide-by-15: lock on the 4th measurement
      for (int i = 0; i < 7; i++) begin
         if (i > 0) push(15, 8, i >= 4);
         gen(8, 7);
      end
      // switch to divide-by-9: first new result unlocks, relocks 3 later
      for (int j = 0; j < 5; j++) begin
         if (j == 0) push(15, 8, 1'b1);
         else        push(9, 4, j == 4);
         gen(4, 5);
      end
      check("locked_before_timeout", 32'(bus.locked), 1);

      // one more edge, then hold low until the period counter saturates
      push(9, 4, 1'b1);
      gen(4, 0);
      bus.sig_in = 1'b0;
      c = 0;
      while (c < 400 && bus.ovf !== 1'b1) begin
         @(negedge clk_in);
         c++;
      end
      check("ovf_set", 32'(bus.ovf), 1);
      checks++;
      assert (c >= 245 && c <= 262) else begin
         errors++;
         $error("FAIL ovf_timing observed=%0d expected=245..262", c);
      end
      check("ovf_locked_clear", 32'(bus.locked), 0);
      check("ovf_period_hold", 32'(bus.period), 9);
      check("ovf_high_hold", 32'(bus.high_len), 4);

      // back in IDLE: first edge yields nothing, no predecessor for the next
      for (int i = 0; i < 5; i++) begin
         if (i > 0) push(9, 4, i == 4);
         gen(4, 5);
      end
      check("ovf_sticky", 32'(bus.ovf), 1);

      // reset in the middle of a locked period
      push(9, 4, 1'b1);
      bus.sig_in = 1'b1;
      repeat (5) @(negedge clk_in);
      check("sb_empty_before_rst", 32'(sb.size()), 0);
      rst = 1'b1;
      bus.sig_in = 1'b0;
      @(negedge clk_in);
      check("mid_rst_period", 32'(bus.period), 0);
      check("mid_rst_high_len", 32'(bus.high_len), 0);
      check("mid_rst_meas_valid", 32'(bus.meas_valid), 0);
      check("mid_rst_locked", 32'(bus.locked), 0);
      check("mid_rst_ovf", 32'(bus.ovf), 0);
      @(negedge clk_in);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) push(9, 4, 1'b0);
         gen(4, 5);
      end

      // alternating input: period 2, high 1
      for (int k = 0; k < 6; k++) begin
         if (k == 0) push(9, 4, 1'b0);
         else        push(2, 1, k >= 4);
         gen(1, 1);
      end
      check("alt_locked", 32'(bus.locked), 1);

      // latency from driving the edge to meas_valid
      bus.sig_in = 1'b0;
      repeat (9) @(negedge clk_in);
      push(11, 1, 1'b0);
      bus.sig_in = 1'b1;
      c = 0;
      while (c < 10 && bus.meas_valid !== 1'b1) begin
         @(negedge clk_in);
         c++;
      end
      check("latency", 32'(c), 32'(LAT));
      bus.sig_in = 1'b0;
      repeat (6) @(negedge clk_in);
      check("sb_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
